// File: rtl/msg_pkg.sv
// -----------------------------------------------------------------------------
// msg_pkg -- shared constants and types for the message scroller.
//   MSG_LEN     : number of characters in the stored message
//   MSG_TEXT    : the message; the first character sits in the top byte
//   ASCII_SPACE : fill character for blank window positions
//   state_t     : scroller states
//   msg_char()  : character lookup with blank fill past the end of the message
// -----------------------------------------------------------------------------
package msg_pkg;

  localparam int MSG_LEN = 16;
  localparam logic [8*MSG_LEN-1:0] MSG_TEXT = "HAPPY VDAY <3 :)";
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int SEL_W = $clog2(8 * MSG_LEN);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Character idx of the message; anything outside the message reads as a space.
  // A string literal packs its first character into the most significant byte.
  function automatic logic [7:0] msg_char(input int idx);
    logic [SEL_W-1:0] lo;
    logic [7:0]       ch;
    if ((idx >= 0) && (idx < MSG_LEN)) begin
      lo = SEL_W'(8 * (MSG_LEN - 1 - idx));
      ch = MSG_TEXT[lo +: 8];
    end else begin
      ch = ASCII_SPACE;
    end
    return ch;
  endfunction

endpackage

// File: rtl/msg_rom.sv
// -----------------------------------------------------------------------------
// msg_rom -- combinational read of WIN consecutive message characters.
//   Parameters: WIN   (characters read), POS_W (width of the base address)
//   base  in   POS_W  : index of the leftmost character
//   chars out  8*WIN  : byte i (bits 8i+7:8i) = message[base+i], or a space
//                       when base+i is past the end of the message
// -----------------------------------------------------------------------------
module msg_rom
  import msg_pkg::*;
#(
  parameter int WIN   = 4,
  parameter int POS_W = 4
) (
  input  logic [POS_W-1:0] base,
  output logic [8*WIN-1:0] chars
);

  // Gather the window one byte at a time.
  always_comb begin
    chars = {WIN{ASCII_SPACE}};
    for (int i = 0; i < WIN; i++) begin
      chars[8*i +: 8] = msg_char(int'(base) + i);
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// -----------------------------------------------------------------------------
// msg_scroller -- scrolls the message from msg_pkg through a WIN-character
// window, one position per tick, then holds the final window for HOLD_TICKS
// ticks and pulses done.
//   Parameters: WIN (window characters), HOLD_TICKS (1..255)
//   clk_in    in   1      : clock, rising edge
//   reset     in   1      : synchronous active-high reset
//   tick      in   1      : single-cycle step pulse
//   start     in   1      : begin a pass (only while idle)
//   pause     in   1      : freeze all state while high
//   win_chars out  8*WIN  : registered window, byte 0 = leftmost character
//   busy      out  1      : scrolling or holding
//   done      out  1      : one-cycle pulse at the end of the hold period
// Configuration macro MSG_SCROLLER_LOOP_EN: when defined the pass restarts
// automatically after the hold; otherwise the block returns to idle.
// -----------------------------------------------------------------------------
module msg_scroller
  import msg_pkg::*;
#(
  parameter int WIN        = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             pause,
  output logic [8*WIN-1:0] win_chars,
  output logic             busy,
  output logic             done
);

  localparam int POS_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(MSG_LEN - WIN);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_TICKS - 1);

  generate
    if ((MSG_LEN < WIN) || (HOLD_TICKS < 1) || (HOLD_TICKS > 255)) begin : g_bad_cfg
      $error("msg_scroller: illegal WIN/HOLD_TICKS configuration");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_nxt;
  logic [7:0]       hold_cnt;
  logic [7:0]       hold_nxt;
  logic             done_nxt;
  logic [8*WIN-1:0] rom_chars;

  // The ROM is addressed with the next position so the window register
  // changes on the same edge as pos.
  msg_rom #(
    .WIN   (WIN),
    .POS_W (POS_W)
  ) u_rom (
    .base  (pos_nxt),
    .chars (rom_chars)
  );

  // Next-state logic; pause holds everything and suppresses done.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    if (pause) begin
      done_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_SCROLL;
            pos_nxt   = '0;
            hold_nxt  = 8'd0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_SCROLL: begin
          if (tick) begin
            // The last window stays in place; the tick that finds it moves to HOLD.
            if (pos == LAST_POS) begin
              state_nxt = ST_HOLD;
              hold_nxt  = 8'd0;
            end else begin
              pos_nxt = pos + 1'b1;
            end
          end else begin
            state_nxt = ST_SCROLL;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              done_nxt = 1'b1;
              hold_nxt = 8'd0;
              pos_nxt  = '0;
`ifdef MSG_SCROLLER_LOOP_EN
              state_nxt = ST_SCROLL;
`else
              state_nxt = ST_IDLE;
`endif
            end else begin
              hold_nxt = hold_cnt + 8'd1;
            end
          end else begin
            state_nxt = ST_HOLD;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          pos_nxt   = '0;
          hold_nxt  = 8'd0;
        end
      endcase
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= ST_IDLE;
      pos       <= '0;
      hold_cnt  <= 8'd0;
      win_chars <= {WIN{ASCII_SPACE}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pos       <= pos_nxt;
      hold_cnt  <= hold_nxt;
      win_chars <= (state_nxt == ST_IDLE) ? {WIN{ASCII_SPACE}} : rom_chars;
      busy      <= (state_nxt != ST_IDLE);
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_msg_scroller.sv
// -----------------------------------------------------------------------------
// tb_msg_scroller -- self-checking bench for msg_scroller.
// The reference model views a pass as a single count of ticks taken since
// start: the window position is that count clipped to the last position, and
// the pass ends when the count reaches the scroll steps plus the hold ticks.
// -----------------------------------------------------------------------------
module tb_msg_scroller;

  localparam int WIN        = 4;
  localparam int HOLD_TICKS = 8;
  localparam int MLEN       = 16;
  localparam int LAST       = MLEN - WIN;
  localparam int TOTAL      = LAST + 1 + HOLD_TICKS;
`ifdef MSG_SCROLLER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             clk_in = 1'b0;
  logic             reset  = 1'b1;
  logic             tick   = 1'b0;
  logic             start  = 1'b0;
  logic             pause  = 1'b0;
  logic [8*WIN-1:0] win_chars;
  logic             busy;
  logic             done;

  string msg = "HAPPY VDAY <3 :)";

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit m_act   = 1'b0;
  int m_steps = 0;
  bit m_done  = 1'b0;

  msg_scroller #(
    .WIN        (WIN),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .pause     (pause),
    .win_chars (win_chars),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8*WIN-1:0] str_win(input string s);
    logic [8*WIN-1:0] w;
    for (int i = 0; i < WIN; i++) w[8*i +: 8] = s[i];
    return w;
  endfunction

  function automatic logic [8*WIN-1:0] win_at(input int p);
    logic [8*WIN-1:0] w;
    for (int i = 0; i < WIN; i++) w[8*i +: 8] = (p + i < MLEN) ? msg[p+i] : 8'h20;
    return w;
  endfunction

  // One clock: apply inputs, take the edge, advance the model, compare.
  task automatic cyc(input logic s, input logic t, input logic p, input logic r);
    logic [8*WIN-1:0] ew;
    start = s; tick = t; pause = p; reset = r;
    @(posedge clk_in);
    #1;
    if (r) begin
      m_act = 1'b0; m_steps = 0; m_done = 1'b0;
    end else if (p) begin
      m_done = 1'b0;
    end else if (!m_act) begin
      m_done = 1'b0;
      if (s) begin m_act = 1'b1; m_steps = 0; end
    end else begin
      m_done = 1'b0;
      if (t) begin
        m_steps++;
        if (m_steps == TOTAL) begin
          m_done = 1'b1; m_steps = 0; m_act = LOOP;
        end
      end
    end
    ew = m_act ? win_at((m_steps < LAST) ? m_steps : LAST) : {WIN{8'h20}};
    check("win",  win_chars, ew);
    check("busy", busy, m_act);
    check("done", done, m_done);
  endtask

  // two idle cycles followed by a tick: one tick every 3 cycles
  task automatic tick3();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_win",  win_chars, 32'h20202020);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    // ticks in idle are ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("idle_tick", busy, 1'b0);

    // start of a pass
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_win",  win_chars, str_win("HAPP"));
    check("start_busy", busy, 1'b1);
    tick3();
    check("tick1_win", win_chars, str_win("APPY"));
    for (int k = 0; k < 4; k++) tick3();
    check("pos5_win", win_chars, str_win(" VDA"));

    // pause for 20 cycles containing 5 ticks
    for (int k = 0; k < 20; k++) cyc(1'b1, (k % 4) == 0, 1'b1, 1'b0);
    check("pause_win", win_chars, str_win(" VDA"));
    tick3();
    check("resume_win", win_chars, str_win("VDAY"));

    // start while scrolling does not restart
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_ign", win_chars, str_win("VDAY"));

    for (int k = 0; k < 6; k++) tick3();
    check("last_win", win_chars, str_win("3 :)"));
    tick3();
    check("hold_win",  win_chars, str_win("3 :)"));
    check("hold_busy", busy, 1'b1);
    for (int k = 0; k < HOLD_TICKS - 1; k++) tick3();
    check("hold_nodone", done, 1'b0);
    tick3();
    check("hold_done", done, 1'b1);
    check("end_busy",  busy, LOOP);
    check("end_win",   win_chars, LOOP ? str_win("HAPP") : 32'h20202020);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("done_once", done, 1'b0);

    // second pass (restart by start only needed without looping)
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TOTAL; k++) tick3();
    check("pass2_done", done, 1'b1);

    // reset in HOLD with hold_cnt = 4
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < LAST + 1 + 4; k++) tick3();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check("hrst_busy", busy, 1'b0);
    check("hrst_win",  win_chars, 32'h20202020);
    check("hrst_done", done, 1'b0);

    // start and tick together while idle
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("st_tick_win", win_chars, str_win("HAPP"));

    // randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
